// File: rtl/axil_pkg.sv
// -----------------------------------------------------------------------------
// axil_pkg
//   Shared definitions for the AXI4-Lite write-side arbitration blocks:
//   controller state encoding, AXI response codes and an index-width helper.
// -----------------------------------------------------------------------------
package axil_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ADDR_DATA = 2'd1,
        S_RESP      = 2'd2
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axil_write_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin winner select. The search starts at
//   last_grant+1 and wraps modulo NUM_REQ, so the previous winner has the
//   lowest priority. Shared by write- and read-side arbiters.
//
//   req         in   NUM_REQ  request vector
//   last_grant  in   IDX_W    index of the previous winner
//   grant       out  NUM_REQ  one-hot winner (all zero when no request)
//   grant_idx   out  IDX_W    binary winner index (0 when no request)
//   grant_valid out  1        at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter
    import axil_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W-1:0] cand;

    // NOTE: every signal written in this always_comb gets a default first,
    // so no path through the loop can leave one unassigned and infer a latch.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        // Explicit modulo keeps the wrap correct for non-power-of-2 NUM_REQ.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axil_write_arbiter.sv
// -----------------------------------------------------------------------------
// axil_write_arbiter
//   Shares one AXI4-Lite write master between NUM_REQ requesters with
//   round-robin arbitration and one outstanding transaction. AW and W are
//   handshaken independently; the B response is returned to the owner as a
//   one-cycle REQ_DONE pulse. An optional watchdog aborts stuck transactions.
//
//   M_AXI_ACLK / M_AXI_ARESETN   clock, async active-low reset
//   REQ_VALID/REQ_READY          per-requester request handshake
//   REQ_AWADDR/WDATA/WSTRB       packed payloads, slice i = requester i
//   REQ_DONE/REQ_RESP            completion pulse and response code
//   M_AXI_AW*/W*/B*              AXI4-Lite write master channels
//   TIMEOUT_ERR                  sticky watchdog flag
//   BUSY                         controller not idle
// -----------------------------------------------------------------------------
module axil_write_arbiter
    import axil_pkg::*;
#(
    parameter int NUM_REQ            = 2,
    parameter int C_M_AXI_ADDR_WIDTH = 18,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                                   M_AXI_ACLK,
    input  logic                                   M_AXI_ARESETN,
    input  logic [NUM_REQ-1:0]                     REQ_VALID,
    output logic [NUM_REQ-1:0]                     REQ_READY,
    input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0]  REQ_AWADDR,
    input  logic [NUM_REQ*C_M_AXI_DATA_WIDTH-1:0]  REQ_WDATA,
    input  logic [NUM_REQ*C_M_AXI_DATA_WIDTH/8-1:0] REQ_WSTRB,
    output logic [NUM_REQ-1:0]                     REQ_DONE,
    output logic [1:0]                             REQ_RESP,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]          M_AXI_AWADDR,
    output logic                                   M_AXI_AWVALID,
    input  logic                                   M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]          M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]        M_AXI_WSTRB,
    output logic                                   M_AXI_WVALID,
    input  logic                                   M_AXI_WREADY,
    input  logic [1:0]                             M_AXI_BRESP,
    input  logic                                   M_AXI_BVALID,
    output logic                                   M_AXI_BREADY,
    output logic                                   TIMEOUT_ERR,
    output logic                                   BUSY
);

    localparam int ADDR_W = C_M_AXI_ADDR_WIDTH;
    localparam int DATA_W = C_M_AXI_DATA_WIDTH;
    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;
    localparam int IDX_W  = idx_width(NUM_REQ);
    localparam int WD_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    // The watchdog fires on the edge that brings the count to TIMEOUT_CYCLES,
    // so valids stay up for exactly TIMEOUT_CYCLES busy cycles.
    localparam logic [WD_W-1:0]    WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    arb_state_t       state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] last_grant;
    logic [WD_W-1:0]  wd_cnt;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic               arb_en;
    logic               wd_hit;
    logic               aw_pending;
    logic               w_pending;

    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic [STRB_W-1:0]  sel_strb;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req         (REQ_VALID),
        .last_grant  (last_grant),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // Arbitration is held off while the completion pulse is out, which
    // guarantees an idle cycle between transactions.
    assign arb_en     = (state == S_IDLE) && (REQ_DONE == '0);
    assign REQ_READY  = arb_en ? arb_grant : '0;
    assign BUSY       = (state != S_IDLE);
    assign wd_hit     = (TIMEOUT_CYCLES > 0) && (wd_cnt == WD_LAST);
    assign aw_pending = M_AXI_AWVALID && !M_AXI_AWREADY;
    assign w_pending  = M_AXI_WVALID && !M_AXI_WREADY;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_strb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_addr = REQ_AWADDR[i*ADDR_W +: ADDR_W];
                sel_data = REQ_WDATA[i*DATA_W +: DATA_W];
                sel_strb = REQ_WSTRB[i*STRB_W +: STRB_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state         <= S_IDLE;
            owner         <= '0;
            last_grant    <= IDX_W'(NUM_REQ - 1);
            wd_cnt        <= '0;
            REQ_DONE      <= '0;
            REQ_RESP      <= RESP_OKAY;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            TIMEOUT_ERR   <= 1'b0;
        end else begin
            REQ_DONE <= '0;

            if (state != S_IDLE && TIMEOUT_CYCLES > 0) begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            unique case (state)
                S_IDLE: begin
                    if (arb_en && arb_valid) begin
                        M_AXI_AWADDR  <= sel_addr;
                        M_AXI_WDATA   <= sel_data;
                        M_AXI_WSTRB   <= sel_strb;
                        owner         <= arb_idx;
                        last_grant    <= arb_idx;
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        wd_cnt        <= '0;
                        state         <= S_ADDR_DATA;
                    end
                end

                S_ADDR_DATA, S_RESP: begin
                    if (wd_hit) begin
                        // Abort: the bus may be left mid-handshake.
                        M_AXI_AWVALID <= 1'b0;
                        M_AXI_WVALID  <= 1'b0;
                        M_AXI_BREADY  <= 1'b0;
                        REQ_DONE      <= ONE_HOT0 << owner;
                        REQ_RESP      <= RESP_SLVERR;
                        TIMEOUT_ERR   <= 1'b1;
                        wd_cnt        <= '0;
                        state         <= S_IDLE;
                    end else if (state == S_ADDR_DATA) begin
                        if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                        if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
                        // Any BVALID seen here is ignored since BREADY is low.
                        if (!aw_pending && !w_pending) begin
                            M_AXI_BREADY <= 1'b1;
                            state        <= S_RESP;
                        end
                    end else if (M_AXI_BVALID && M_AXI_BREADY) begin
                        M_AXI_BREADY <= 1'b0;
                        REQ_DONE     <= ONE_HOT0 << owner;
                        REQ_RESP     <= M_AXI_BRESP;
                        state        <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axil_write_arbiter
//   Directed bench: a table of transactions with hand-computed winners and
//   responses driven through a cycle-level slave model, followed by
//   hand-written watchdog and mid-transaction reset sequences.
// -----------------------------------------------------------------------------
module tb_axil_write_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 18;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_awaddr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ*SW-1:0]   req_wstrb;
    logic [NREQ-1:0]      req_done;
    logic [1:0]           req_resp;
    logic [AW-1:0]        awaddr;
    logic                 awvalid;
    logic                 awready;
    logic [DW-1:0]        wdata;
    logic [SW-1:0]        wstrb;
    logic                 wvalid;
    logic                 wready;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;
    logic                 timeout_err;
    logic                 busy;

    always #5 clk = ~clk;

    axil_write_arbiter #(
        .NUM_REQ            (NREQ),
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES     (8)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .REQ_VALID     (req_valid),
        .REQ_READY     (req_ready),
        .REQ_AWADDR    (req_awaddr),
        .REQ_WDATA     (req_wdata),
        .REQ_WSTRB     (req_wstrb),
        .REQ_DONE      (req_done),
        .REQ_RESP      (req_resp),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .TIMEOUT_ERR   (timeout_err),
        .BUSY          (busy)
    );

    typedef struct {
        logic [1:0]  req;
        bit          hold;
        logic [17:0] addr0, addr1;
        logic [31:0] data0, data1;
        logic [3:0]  strb0, strb1;
        int          aw_dly, w_dly, b_start;
        logic [1:0]  resp;
        logic [1:0]  exp_grant;
    } txn_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_grant(output logic [1:0] g);
        g = '0;
        for (int w = 0; w < 6; w++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                g = req_ready;
                break;
            end
        end
        check("grant_seen", (g != '0), 1'b1);
    endtask

    task automatic run_txn(input txn_t t, input int n);
        logic [1:0]  g;
        logic [17:0] ea;
        logic [31:0] ed;
        logic [3:0]  es;
        bit aw_done, w_done, b_done;
        aw_done = 0; w_done = 0; b_done = 0;
        ea = (t.exp_grant == 2'b01) ? t.addr0 : t.addr1;
        ed = (t.exp_grant == 2'b01) ? t.data0 : t.data1;
        es = (t.exp_grant == 2'b01) ? t.strb0 : t.strb1;

        @(posedge clk); #1;
        req_valid  = t.req;
        req_awaddr = {t.addr1, t.addr0};
        req_wdata  = {t.data1, t.data0};
        req_wstrb  = {t.strb1, t.strb0};
        wait_grant(g);
        check($sformatf("t%0d_grant", n), g, t.exp_grant);

        @(posedge clk); #1;
        // The captured payload must not follow the inputs after acceptance.
        req_awaddr = ~req_awaddr;
        req_wdata  = ~req_wdata;
        req_wstrb  = ~req_wstrb;
        if (!t.hold) req_valid = '0;

        for (int c = 1; c <= 12 && !b_done; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            awready = (c >= t.aw_dly) && !aw_done;
            wready  = (c >= t.w_dly) && !w_done;
            bvalid  = (c >= t.b_start);
            bresp   = t.resp;
            @(negedge clk);
            check($sformatf("t%0d_c%0d_awvalid", n, c), awvalid, !aw_done);
            check($sformatf("t%0d_c%0d_wvalid", n, c), wvalid, !w_done);
            check($sformatf("t%0d_c%0d_bready", n, c), bready, aw_done && w_done);
            check($sformatf("t%0d_c%0d_ready", n, c), req_ready, 2'b00);
            check($sformatf("t%0d_c%0d_done", n, c), req_done, 2'b00);
            if (awvalid) check($sformatf("t%0d_c%0d_awaddr", n, c), awaddr, ea);
            if (wvalid) begin
                check($sformatf("t%0d_c%0d_wdata", n, c), wdata, ed);
                check($sformatf("t%0d_c%0d_wstrb", n, c), wstrb, es);
            end
            if (bready && bvalid) b_done = 1;
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
        end
        check($sformatf("t%0d_b_handshake", n), b_done, 1'b1);

        @(posedge clk); #1;
        awready = 0; wready = 0; bvalid = 0;
        @(negedge clk);
        check($sformatf("t%0d_done", n), req_done, t.exp_grant);
        check($sformatf("t%0d_resp", n), req_resp, t.resp);
        check($sformatf("t%0d_busy", n), busy, 1'b0);
        check($sformatf("t%0d_bready_low", n), bready, 1'b0);
        check($sformatf("t%0d_no_ready_in_done", n), req_ready, 2'b00);
    endtask

    txn_t tbl[7];

    initial begin
        logic [1:0] g;

        tbl[0] = '{2'b01, 0, 18'h00010, 18'h20000, 32'hDEADBEEF, 32'hCAFEF00D, 4'hF, 4'h3, 1, 1, 2, 2'b00, 2'b01};
        tbl[1] = '{2'b11, 1, 18'h00100, 18'h00204, 32'h11111111, 32'h22222222, 4'h1, 4'h2, 1, 1, 2, 2'b00, 2'b10};
        tbl[2] = '{2'b11, 1, 18'h00300, 18'h00304, 32'h33333333, 32'h44444444, 4'h4, 4'h8, 4, 1, 1, 2'b01, 2'b01};
        tbl[3] = '{2'b11, 1, 18'h00400, 18'h3FFFC, 32'h55555555, 32'hA5A5A5A5, 4'hF, 4'hC, 1, 4, 3, 2'b11, 2'b10};
        tbl[4] = '{2'b11, 0, 18'h00500, 18'h00504, 32'h66666666, 32'h77777777, 4'h3, 4'h6, 2, 2, 3, 2'b10, 2'b01};
        tbl[5] = '{2'b10, 0, 18'h00600, 18'h1ABCD, 32'h00000000, 32'h12345678, 4'h0, 4'h9, 3, 3, 4, 2'b00, 2'b10};
        tbl[6] = '{2'b10, 0, 18'h00700, 18'h00704, 32'h00000000, 32'h87654321, 4'h0, 4'hF, 2, 1, 5, 2'b01, 2'b10};

        req_valid = '0; req_awaddr = '0; req_wdata = '0; req_wstrb = '0;
        awready = 0; wready = 0; bresp = 2'b00; bvalid = 0;

        // Reset state.
        #1;
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_done", req_done, 2'b00);
        check("rst_resp", req_resp, 2'b00);
        check("rst_timeout", timeout_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_awaddr", awaddr, 18'h0);
        @(negedge clk); @(negedge clk); #1;
        rst_n = 1'b1;

        for (int n = 0; n < 7; n++) run_txn(tbl[n], n);

        // Watchdog: AW never accepted; last_grant is 1 so requester 0 wins.
        check("wd_err_before", timeout_err, 1'b0);
        @(posedge clk); #1;
        req_valid = 2'b01; req_awaddr = {18'h0, 18'h00ABC};
        wait_grant(g);
        check("wd_grant", g, 2'b01);
        @(posedge clk); #1;
        req_valid = '0; awready = 0; wready = 1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("wd_c%0d_awvalid", c), awvalid, 1'b1);
            check($sformatf("wd_c%0d_wvalid", c), wvalid, (c == 1));
            check($sformatf("wd_c%0d_done", c), req_done, 2'b00);
            @(posedge clk); #1;
            wready = 0;
        end
        @(negedge clk);
        check("wd_awvalid_drop", awvalid, 1'b0);
        check("wd_wvalid", wvalid, 1'b0);
        check("wd_bready", bready, 1'b0);
        check("wd_done", req_done, 2'b01);
        check("wd_resp", req_resp, 2'b10);
        check("wd_err_set", timeout_err, 1'b1);
        check("wd_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        check("wd_err_sticky", timeout_err, 1'b1);
        check("wd_done_once", req_done, 2'b00);

        // Reset in S_RESP: last_grant is 0 so requester 1 wins this one.
        @(posedge clk); #1;
        req_valid = 2'b10; req_awaddr = {18'h01234, 18'h0};
        wait_grant(g);
        check("rs_grant", g, 2'b10);
        @(posedge clk); #1;
        req_valid = '0; awready = 1; wready = 1;
        @(posedge clk); #1;
        awready = 0; wready = 0;
        @(negedge clk);
        check("rs_bready_before", bready, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("rs_bready_async", bready, 1'b0);
        check("rs_awvalid", awvalid, 1'b0);
        check("rs_busy", busy, 1'b0);
        check("rs_done", req_done, 2'b00);
        check("rs_err_cleared", timeout_err, 1'b0);
        @(negedge clk);
        check("rs_done_hold", req_done, 2'b00);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        req_valid = 2'b11;
        @(negedge clk);
        check("rs_done_after", req_done, 2'b00);
        check("rs_next_grant", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench did not finish");
    end

endmodule

// File: doc/axil_write_arbiter.md
Name: axil_write_arbiter

Overview:
- Shares one AXI4-Lite write master port between NUM_REQ write requesters, e.g. the UART-to-SRAM loader and a host/debug writer.
- Round-robin arbitration.
- One outstanding transaction at a time.
- AW and W channels are handshaken independently; the B response is routed back to the owning requester.
- Sits between the requesters and the system bus, in front of the embedded-memory AXI slave.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- C_M_AXI_ADDR_WIDTH, 18, write address width.
- C_M_AXI_DATA_WIDTH, 32, write data width; strobe width is C_M_AXI_DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, watchdog limit per transaction; 0 disables the watchdog.

Ports:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESETN  in  1  reset; asynchronous, active-low.
- REQ_VALID  in  NUM_REQ  requester i has a write pending.
- REQ_READY  out  NUM_REQ  requester i's payload is accepted this cycle.
- REQ_AWADDR  in  NUM_REQ*ADDR_W  packed addresses; slice i belongs to requester i.
- REQ_WDATA  in  NUM_REQ*DATA_W  packed data.
- REQ_WSTRB  in  NUM_REQ*DATA_W/8  packed strobes.
- REQ_DONE  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- REQ_RESP  out  2  response code; valid only while any REQ_DONE bit is high.
- M_AXI_AWADDR  out  ADDR_W  write address.
- M_AXI_AWVALID  out  1  write address valid.
- M_AXI_AWREADY  in  1  write address ready.
- M_AXI_WDATA  out  DATA_W  write data.
- M_AXI_WSTRB  out  DATA_W/8  write strobes.
- M_AXI_WVALID  out  1  write data valid.
- M_AXI_WREADY  in  1  write data ready.
- M_AXI_BRESP  in  2  write response code.
- M_AXI_BVALID  in  1  write response valid.
- M_AXI_BREADY  out  1  write response ready.
- TIMEOUT_ERR  out  1  sticky; set when the watchdog fires.
- BUSY  out  1  high whenever state is not S_IDLE.

Behaviour:
- Reset values: all outputs 0. State S_IDLE. Round-robin pointer last_grant = NUM_REQ-1, so requester 0 wins first. Watchdog counter 0.
- Reset mid-transaction: all valids drop immediately (asynchronous reset); no REQ_DONE is generated.

States:
- S_IDLE
- S_ADDR_DATA
- S_RESP

Arbitration (S_IDLE only):
- Winner = first i with REQ_VALID[i] set, searching from last_grant+1 upward modulo NUM_REQ.
- REQ_READY[i] is combinational: state==S_IDLE and i is the winner. At most one bit is set; it is 0 outside S_IDLE.
- On that edge the block latches:
  - the winner's address, data and strobe slices into the M_AXI_* registers;
  - the owner index;
  - last_grant = winner.
- On that same edge it sets AWVALID=1, WVALID=1, clears the watchdog, and moves to S_ADDR_DATA.
- Latency: REQ_VALID sampled in cycle N gives AWVALID/WVALID high in cycle N+1.
- Requesters hold REQ_VALID and payload stable until REQ_READY; they may drop REQ_VALID afterwards.

S_ADDR_DATA:
- AWVALID clears on the edge where AWVALID&&AWREADY; WVALID clears on the edge where WVALID&&WREADY. The two may complete in either order or in the same cycle.
- AWADDR, WDATA and WSTRB never change while their valid is high.
- Once both channels have completed: BREADY=1 on the next edge, move to S_RESP.
- If BVALID arrives while either channel is still incomplete, it is ignored (BREADY stays 0).

S_RESP:
- On BVALID&&BREADY: BREADY=0, REQ_DONE[owner]=1 for one cycle, REQ_RESP=BRESP, return to S_IDLE.
- New arbitration can occur in the cycle after REQ_DONE, i.e. one idle cycle minimum between transactions.

Watchdog (TIMEOUT_CYCLES>0):
- Counts every cycle in S_ADDR_DATA and S_RESP.
- When the count reaches TIMEOUT_CYCLES: drop AWVALID, WVALID and BREADY; pulse REQ_DONE[owner] with REQ_RESP=2'b10 (SLVERR); set TIMEOUT_ERR; return to S_IDLE.
- Debug guard only; the bus may be left in a non-compliant state.
- TIMEOUT_ERR clears only on reset.

Width rules:
- Watchdog counter width is $clog2(TIMEOUT_CYCLES+1).
- Owner and pointer width is $clog2(NUM_REQ), minimum 1.
- Pointer wrap-around uses explicit modulo NUM_REQ (required for non-power-of-2 NUM_REQ).

Decomposition:
- Shared package axil_pkg:
  - state enum arb_state_t {S_IDLE, S_ADDR_DATA, S_RESP};
  - AXI response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
- One sub-module: rr_arbiter. Combinational round-robin winner select; inputs request vector and last_grant; outputs one-hot grant and index. Reusable for a future read-side arbiter.

Test Plan:
- Single request: REQ_VALID=2'b01, addr 0x00010, data 0xDEADBEEF, AWREADY/WREADY high, BVALID one cycle later with BRESP=0 -> REQ_READY[0] in cycle 0; AW/W valid in cycle 1; REQ_DONE[0] pulse, REQ_RESP=00; last_grant=0.
- Simultaneous requests: REQ_VALID=2'b11 held for 4 transactions -> grants alternate 0,1,0,1; no REQ_READY while BUSY.
- Split handshakes:
  - WREADY 3 cycles before AWREADY -> WVALID drops first; AWADDR stable until AW accepted; BREADY rises only after both.
  - Reverse order (AWREADY first) -> same result with AWVALID dropping first.
- Response routing: requester 1 granted, BRESP=2'b11 -> REQ_DONE=2'b10, REQ_RESP=2'b11; requester 0 sees no pulse.
- Watchdog: TIMEOUT_CYCLES=8, AWREADY held low -> after 8 cycles valids drop, REQ_DONE[owner] with RESP=10, TIMEOUT_ERR=1 stays set.
- Reset mid-transaction: assert M_AXI_ARESETN=0 in S_RESP -> BREADY=0 immediately; no REQ_DONE; next grant goes to requester 0.
